// File: rtl/exec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_seq_pkg
// Brief    : Shared opcode/function constants, write-destination encodings
//            and the sequencer state type for the execute-stage sequencer.
// Revision : 1.0  initial release
// ============================================================================
package exec_seq_pkg;

    // Opcode / function-field values recognised by the sequencer
    localparam logic [3:0] OP_TYPEA = 4'b1111;
    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] FN_MUL   = 4'b0100;
    localparam logic [3:0] FN_DIV   = 4'b0101;
    localparam logic [3:0] FN_SWAP  = 4'b1000;

    // Register-file write-address select encodings
    localparam logic [1:0] WDST_RD = 2'b00;
    localparam logic [1:0] WDST_RS = 2'b01;
    localparam logic [1:0] WDST_HI = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MD_WAIT  = 3'd1,
        ST_MD_WB_HI = 3'd2,
        ST_SWAP_WB2 = 3'd3,
        ST_HALT     = 3'd4
    } seq_state_t;

endpackage : exec_seq_pkg
`default_nettype wire

// File: rtl/instr_class_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_class_decode
// Brief    : Combinational classification of opcode/func into the
//            instruction classes that need sequencer involvement.
// Revision : 1.0  initial release
// ============================================================================
module instr_class_decode
    import exec_seq_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [3:0] i_func,
    output logic       o_is_md,
    output logic       o_is_div,
    output logic       o_is_swap,
    output logic       o_is_halt
);

    logic w_typea;

    // Map opcode/func to instruction class flags
    always_comb begin
        w_typea   = (i_opcode == OP_TYPEA);
        o_is_div  = w_typea && (i_func == FN_DIV);
        o_is_md   = w_typea && ((i_func == FN_MUL) || (i_func == FN_DIV));
        o_is_swap = w_typea && (i_func == FN_SWAP);
        o_is_halt = (i_opcode == OP_HALT);
    end

endmodule : instr_class_decode
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Brief    : Multi-cycle execution sequencer. Stalls the front end for
//            MUL/DIV/SWAP, launches the shared mul/div unit, owns the RF
//            write port for two-writeback sequences and latches HALT.
// Revision : 1.0  initial release
// ============================================================================
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int MD_LATENCY = 16,
    parameter int CNT_W      = $clog2(MD_LATENCY)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [3:0] opcode,
    input  logic [3:0] func,
    output logic       md_start,
    output logic       md_op,
    input  logic       md_done,
    output logic       stall,
    output logic       seq_own,
    output logic       rf_we,
    output logic [1:0] wdst_sel,
    output logic       halted,
    output logic       md_timeout
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MD_LATENCY - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_md_op;
    logic             r_md_timeout;

    logic w_is_md;
    logic w_is_div;
    logic w_is_swap;
    logic w_is_halt;
    logic w_accept;

    instr_class_decode u_decode (
        .i_opcode  (opcode),
        .i_func    (func),
        .o_is_md   (w_is_md),
        .o_is_div  (w_is_div),
        .o_is_swap (w_is_swap),
        .o_is_halt (w_is_halt)
    );

    // An instruction is only taken in IDLE; rst_n gating keeps every output
    // low while reset is held, even if a valid MUL/SWAP sits on the inputs.
    assign w_accept   = rst_n && instr_valid && (r_state == ST_IDLE);
    assign md_timeout = r_md_timeout;

    // State, wait counter, latched operation and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_md_op      <= 1'b0;
            r_md_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        if (w_is_md) begin
                            r_md_op <= w_is_div;
                            r_cnt   <= '0;
                            r_state <= ST_MD_WAIT;
                        end else if (w_is_swap) begin
                            r_state <= ST_SWAP_WB2;
                        end else if (w_is_halt) begin
                            r_state <= ST_HALT;
                        end
                    end
                end
                ST_MD_WAIT: begin
                    // A done arriving on the last allowed cycle still wins
                    if (md_done) begin
                        r_state <= ST_MD_WB_HI;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_md_timeout <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_MD_WB_HI: r_state <= ST_IDLE;
                ST_SWAP_WB2: r_state <= ST_IDLE;
                ST_HALT:     r_state <= ST_HALT;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    // Control outputs: the issue cycle reacts to the decoded instruction in
    // the same cycle, later cycles follow the state. md_op is only driven
    // while the mul/div operation is in flight so idle outputs stay at zero.
    always_comb begin
        md_start = 1'b0;
        md_op    = 1'b0;
        stall    = 1'b0;
        seq_own  = 1'b0;
        rf_we    = 1'b0;
        wdst_sel = WDST_RD;
        halted   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_md) begin
                    md_start = 1'b1;
                    md_op    = w_is_div;
                    stall    = 1'b1;
                end else if (w_accept && w_is_swap) begin
                    seq_own  = 1'b1;
                    rf_we    = 1'b1;
                    wdst_sel = WDST_RD;
                    stall    = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                stall = 1'b1;
                md_op = r_md_op;
                if (md_done) begin
                    seq_own  = 1'b1;
                    rf_we    = 1'b1;
                    wdst_sel = WDST_RD;
                end
            end
            ST_MD_WB_HI: begin
                seq_own  = 1'b1;
                rf_we    = 1'b1;
                wdst_sel = WDST_HI;
            end
            ST_SWAP_WB2: begin
                seq_own  = 1'b1;
                rf_we    = 1'b1;
                wdst_sel = WDST_RS;
            end
            ST_HALT: begin
                halted = 1'b1;
                stall  = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule : exec_sequencer
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execution sequencer for the 16-bit datapath; sits beside the combinational decoder in the decode/execute stage.
- Stalls fetch/decode for multi-cycle instructions and starts the shared multiply/divide unit.
- Owns the single register-file write port for sequences that need two writebacks: MUL/DIV low+high word, and SWAP's two registers.
- Latches HALT.

Parameters:
- MD_LATENCY, 16: cycles allowed in MD_WAIT for md_done before timeout; must be >= 2.
- CNT_W, $clog2(MD_LATENCY): wait-counter width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  decoded instruction present this cycle
- opcode  in  4  instruction opcode
- func  in  4  type-A function field
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_op  out  1  0 = MUL, 1 = DIV; valid with md_start and held through MD_WAIT
- md_done  in  1  mul/div result valid (pulse)
- stall  out  1  hold PC/IR; no new instruction accepted
- seq_own  out  1  sequencer drives the RF write port this cycle
- rf_we  out  1  RF write enable; meaningful when seq_own = 1
- wdst_sel  out  2  RF write-address select: 00 rd, 01 rs (second SWAP write), 10 R15 (high word)
- halted  out  1  processor halted
- md_timeout  out  1  sticky error: md_done never arrived

Behaviour:
- Decode classes:
  - MUL: opcode 1111, func 0100.
  - DIV: opcode 1111, func 0101.
  - SWAP: opcode 1111, func 1000.
  - HALT: opcode 0000.
  - Everything else is single-cycle: sequencer passive, seq_own = 0, stall = 0.
- States: IDLE, MD_WAIT, MD_WB_HI, SWAP_WB2, HALT.
- Reset (async, rst_n = 0):
  - State goes to IDLE; counter = 0; md_op = 0; md_timeout = 0.
  - All outputs 0.
  - Reset mid-sequence abandons the sequence with no further writes and no md_start reissue.
- IDLE, instr_valid = 0: all outputs 0, stay.
- IDLE, MUL/DIV:
  - Combinational in the same cycle: md_start = 1, stall = 1; md_op registered (MUL 0, DIV 1).
  - Counter cleared; next state MD_WAIT.
- MD_WAIT: stall = 1.
  - md_done = 1: seq_own = 1, rf_we = 1, wdst_sel = 00 (low word to rd); next MD_WB_HI.
  - Otherwise counter increments. When counter == MD_LATENCY-1 with no md_done: set md_timeout, go IDLE, no RF writes. The instruction retires; stall = 0 next cycle.
  - md_done in the same cycle as the timeout count: done wins, no timeout.
  - md_done in the first MD_WAIT cycle (1-cycle unit) is legal.
- MD_WB_HI: seq_own = 1, rf_we = 1, wdst_sel = 10, stall = 0 (instruction retires); next IDLE.
- MUL/DIV latency = 1 issue cycle + wait cycles + 1 = minimum 3 cycles of ownership.
- IDLE, SWAP: seq_own = 1, rf_we = 1, wdst_sel = 00, stall = 1; next SWAP_WB2.
- SWAP_WB2: seq_own = 1, rf_we = 1, wdst_sel = 01, stall = 0; next IDLE. SWAP occupies exactly 2 cycles.
- IDLE, HALT: next HALT. In HALT: halted = 1, stall = 1, all else 0. Only reset exits.
- md_done outside MD_WAIT is ignored.
- instr_valid is ignored outside IDLE, since stall holds the IR.
- md_timeout is sticky until reset and does not block further instructions.
- Back-to-back multi-cycle instructions: the next one is accepted in the IDLE cycle immediately after the retiring cycle. There are no bubble cycles beyond that.
- md_start is never asserted outside the IDLE issue cycle.

Decomposition:
- Package exec_seq_pkg:
  - opcode/func constants (OP_TYPEA, OP_HALT, FN_MUL, FN_DIV, FN_SWAP).
  - state enum.
  - WDST_RD / WDST_RS / WDST_HI encodings.
- One natural sub-module, instr_class_decode: combinational opcode/func to {is_md, is_div, is_swap, is_halt}, reusable by the hazard logic.
- The FSM and the timeout counter stay in exec_sequencer.

Test Plan:
- MUL (1111/0100), md_done 3 cycles after md_start:
  - md_start at cycle 0, md_op = 0, stall high cycles 0–3.
  - rf_we with wdst_sel 00 at cycle 3, 10 at cycle 4 with stall = 0; IDLE at cycle 5.
- DIV with md_done in the first MD_WAIT cycle: md_op = 1; writes at cycles 1 (00) and 2 (10); total 3 cycles.
- SWAP followed immediately by MUL:
  - rf_we/seq_own 2 cycles, wdst_sel 00 then 01; stall 1 then 0.
  - MUL md_start in the very next cycle.
- MD_LATENCY = 4, md_done never asserted: md_timeout = 1 after 4 MD_WAIT cycles; zero RF writes; next instruction accepted.
- Variant: md_done in the 4th MD_WAIT cycle → no timeout, normal writes.
- HALT (opcode 0000): halted = 1 and stall = 1 indefinitely; instr_valid/MUL ignored; rst_n pulse low → IDLE, halted = 0.
- rst_n asserted asynchronously mid-MD_WAIT and mid-SWAP_WB2: outputs 0 immediately without a clock edge; a later md_done produces no write.
